// File: rtl/dispatch_queue_pkg.sv
// Shared dispatch definitions: default queue geometry and payload typedefs.
// The dispatch payload width is set here once so producers, consumers and
// the queue itself agree on it.
package dispatch_queue_pkg;

  localparam int DISPATCH_WIDTH = 32;
  localparam int DISPATCH_DEPTH = 4;

  typedef logic [DISPATCH_WIDTH-1:0] dispatch_payload_t;

  // Per-cycle handshake outcome, handy for anything that tracks queue traffic.
  typedef struct packed {
    logic push;
    logic pop;
  } dispatch_op_t;

endpackage

// File: rtl/dispatch_queue.sv
// Dispatch queue: a small synchronous FIFO between instruction decode and
// issue. Outputs come only from registered state, so there is no
// combinational path from any input to any output. A flush discards all
// entries in one cycle by clearing the pointers and count.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int WIDTH = DISPATCH_WIDTH,
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  dispatch_op_t     op;

  // Occupancy flags and the handshake decisions; push is refused whenever
  // the queue is full, even if a pop happens in the same cycle.
  always_comb begin
    o_full  = (count == CW'(DEPTH));
    o_empty = (count == '0);
    o_ready = !o_full;
    o_valid = !o_empty;
    o_data  = storage[head];
    o_count = count;
    op.push = i_valid && o_ready;
    op.pop  = o_valid && i_ready;
  end

  // Pointer and count update; reset beats flush, flush beats push and pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (op.push) begin
        tail <= tail + PW'(1);
      end
      if (op.pop) begin
        head <= head + PW'(1);
      end
      if (op.push && !op.pop) begin
        count <= count + CW'(1);
      end else if (op.pop && !op.push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Payload storage has no reset; a flushed or reset entry is simply
  // unreachable until overwritten.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && op.push) begin
      storage[tail] <= i_data;
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed testbench for dispatch_queue at WIDTH=8, DEPTH=4.
// Inputs are driven 1 ns after each rising edge and outputs are sampled
// there too, well away from the active edge.
module tb_dispatch_queue;

  logic       i_clk;
  logic       i_rst;
  logic       i_flush;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_ready;
  logic [2:0] o_count;
  logic       o_full;
  logic       o_empty;

  int n_checks;
  int n_fail;

  dispatch_queue #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  // Free-running 10 ns clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rst   = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = 8'h00;
  endtask

  task automatic push_one(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
    n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty got %b want 1", o_empty); end
    n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full got %b want 0", o_full); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", o_ready); end
    n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", o_count); end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(vals[i]);
      n_checks++; if (o_count !== 3'(i + 1)) begin n_fail++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, o_count, i + 1); end
    end
    n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full got %b want 1", o_full); end
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_ready got %b want 0", o_ready); end
    push_one(8'h55);
    n_checks++; if (o_count !== 3'd4) begin n_fail++; $display("[TB] FAIL overflow_count got %0d want 4", o_count); end
    n_checks++; if (o_data !== 8'h11) begin n_fail++; $display("[TB] FAIL overflow_head got %h want 11", o_data); end
  endtask

  task automatic test_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (o_valid !== 1'b1 || o_data !== vals[i]) begin n_fail++; $display("[TB] FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, o_valid, o_data, vals[i]); end
      tick();
    end
    i_ready = 1'b0;
    n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_empty got %b want 1", o_empty); end
    n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("[TB] FAIL drain_count got %0d want 0", o_count); end
  endtask

  task automatic test_latency();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'hA0;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_same_cycle got %b want 0", o_valid); end
    tick();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1 || o_data !== 8'hA0) begin n_fail++; $display("[TB] FAIL latency_next_cycle got v=%b d=%h want v=1 d=a0", o_valid, o_data); end
    // Hold: nothing offered, nothing taken, state must not move.
    tick();
    tick();
    n_checks++; if (o_count !== 3'd1 || o_data !== 8'hA0) begin n_fail++; $display("[TB] FAIL hold got c=%0d d=%h want c=1 d=a0", o_count, o_data); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL latency_pop_empty got %b want 1", o_empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] model[$];
    logic [7:0] want;
    push_one(8'hB0); model.push_back(8'hB0);
    push_one(8'hB1); model.push_back(8'hB1);
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_data = 8'hC0 + 8'(i);
      want = model[0];
      #1;
      n_checks++; if (o_data !== want || o_count !== 3'd2) begin n_fail++; $display("[TB] FAIL b2b[%0d] got d=%h c=%0d want d=%h c=2", i, o_data, o_count, want); end
      tick();
      void'(model.pop_front());
      model.push_back(i_data);
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    n_checks++; if (o_count !== 3'd2 || o_data !== 8'hC8) begin n_fail++; $display("[TB] FAIL b2b_final got d=%h c=%0d want d=c8 c=2", o_data, o_count); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_flush();
    push_one(8'hD1);
    push_one(8'hD2);
    push_one(8'hD3);
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'hEE;
    i_ready = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush got c=%0d v=%b want c=0 v=0", o_count, o_valid); end
    push_one(8'h5A);
    n_checks++; if (o_count !== 3'd1 || o_data !== 8'h5A) begin n_fail++; $display("[TB] FAIL flush_dropped got c=%0d d=%h want c=1 d=5a", o_count, o_data); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    n_checks++; if (o_empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_after_pop got %b want 1", o_empty); end
  endtask

  task automatic test_reset_flush();
    push_one(8'h61);
    push_one(8'h62);
    i_rst   = 1'b1;
    i_flush = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h63;
    i_ready = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (o_valid !== 1'b0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0) begin
      n_fail++; $display("[TB] FAIL rst_flush_state got v=%b e=%b f=%b r=%b c=%0d want v=0 e=1 f=0 r=1 c=0", o_valid, o_empty, o_full, o_ready, o_count);
    end
    i_valid = 1'b1;
    i_data  = 8'h77;
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_push_same_cycle got %b want 0", o_valid); end
    tick();
    i_valid = 1'b0;
    n_checks++; if (o_valid !== 1'b1 || o_data !== 8'h77 || o_count !== 3'd1) begin n_fail++; $display("[TB] FAIL rst_push_head got v=%b d=%h c=%0d want v=1 d=77 c=1", o_valid, o_data, o_count); end
  endtask

  // Scenario sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_back_to_back();
    test_flush();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 4: entry count, power of two, >=2.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_flush, input, 1: synchronous discard of all entries (mispredict/exception).
REQ-006 SHALL have port i_valid, input, 1: producer offers i_data this cycle.
REQ-007 SHALL have port i_data, input, WIDTH: producer payload.
REQ-008 SHALL have port o_ready, output, 1: queue accepts a push this cycle.
REQ-009 SHALL have port o_valid, output, 1: head entry present on o_data.
REQ-010 SHALL have port o_data, output, WIDTH: head payload.
REQ-011 SHALL have port i_ready, input, 1: consumer takes the head this cycle.
REQ-012 SHALL have port o_count, output, $clog2(DEPTH+1): current occupancy.
REQ-013 SHALL have ports o_full and o_empty, output, 1 each: occupancy == DEPTH / == 0.

Function
REQ-014 SHALL push when i_valid && o_ready, writing i_data at the tail and advancing the tail pointer modulo DEPTH.
REQ-015 SHALL pop when o_valid && i_ready, advancing the head pointer modulo DEPTH.
REQ-016 SHALL drive o_ready = !o_full combinationally; a push while full is refused even if a pop occurs in the same cycle.
REQ-017 SHALL drive o_valid = !o_empty and o_data = storage[head] combinationally from registered state; no input-to-output combinational path.
REQ-018 SHALL give push-to-o_valid latency of exactly one cycle on an empty queue (no bypass).
REQ-019 SHALL handle simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-020 SHALL preserve FIFO order across pointer wrap-around.
REQ-021 SHALL hold all state when neither push nor pop occurs.
REQ-022 SHALL give i_flush priority over push and pop in the same cycle: next cycle count = 0, head = tail = 0; the offered push is dropped.
REQ-023 SHALL keep o_count equal to pushes minus pops since the last reset/flush, saturating never beyond 0..DEPTH.
REQ-024 SHALL NOT clear storage contents on flush; only pointers and count are cleared.

Reset
REQ-025 SHALL, on i_rst high at a rising i_clk edge, set head = tail = 0 and count = 0, giving o_valid = 0, o_empty = 1, o_full = 0, o_ready = 1, o_count = 0.
REQ-026 SHALL give i_rst priority over i_flush, push and pop.
REQ-027 SHALL NOT require storage reset; o_data is don't-care while o_valid = 0.
REQ-028 SHALL, when reset is asserted mid-operation, discard all entries with the same result as REQ-025.

Structure
REQ-029 SHALL take WIDTH/DEPTH defaults from localparams in the shared utils package alongside the dispatch payload typedefs, so the dispatch payload width is set in one place.
REQ-030 SHALL implement storage as an inline register array with head/tail pointers of $clog2(DEPTH) bits and a separate count register; no sub-module is required.

Verification (WIDTH=8, DEPTH=4)
REQ-031 SHALL check: reset, then push 0x11,0x22,0x33,0x44 with i_ready=0 -> o_full=1, o_ready=0, o_count=4; a fifth push of 0x55 is ignored.
REQ-032 SHALL check: full queue, i_ready=1 for 4 cycles -> o_data sequence 0x11,0x22,0x33,0x44, then o_empty=1.
REQ-033 SHALL check: push 0xA0 into an empty queue -> o_valid=0 the same cycle, o_valid=1 with o_data=0xA0 the next cycle.
REQ-034 SHALL check: count=2, push and pop together for 10 cycles across the wrap -> o_count stays 2 and output order matches input order.
REQ-035 SHALL check: count=3, i_flush with i_valid=1 and i_ready=1 -> next cycle o_count=0, o_valid=0, and the pushed value never appears.
REQ-036 SHALL check: i_rst and i_flush both high with count=2 -> reset state per REQ-025; a push the following cycle appears at the head one cycle later.
